// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder
//   Memory-mapped UART responder on the CPU IO page (mem_addr[22] = 1).
//   CPU writes are buffered in a TX FIFO and drained into a byte-level uart_tx.
//   Bytes from uart_rx are buffered in an RX FIFO until the CPU reads them.
//   Register select is one-hot on byte address bits [5:3] (word bits [3:1]):
//     bit3 TXDATA (W), bit4 RXDATA (R), bit5 STATUS (R/W); priority TX > RX > STATUS.
//   Optional feature macro: UART_IRQ_EN adds the irq output and the STATUS irq_en bit.
module uart_mmio_responder #(
  parameter int TX_DEPTH_LOG2 = 2,
  parameter int RX_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte
`ifdef UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] TX_PTR_ONE = (TX_DEPTH_LOG2+1)'(1);
  localparam logic [RX_DEPTH_LOG2:0] RX_PTR_ONE = (RX_DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic io_sel, wr, rd;
  logic hit_tx, hit_rx, hit_st;

  assign io_sel = mem_addr[22];
  assign wr     = io_sel & (|mem_wmask);
  assign rd     = io_sel & mem_rstrb;
  assign hit_tx = mem_addr[3];
  assign hit_rx = ~mem_addr[3] & mem_addr[4];
  assign hit_st = ~mem_addr[3] & ~mem_addr[4] & mem_addr[5];

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]             tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2:0] tx_wp, tx_rp;
  logic                   tx_full, tx_empty, tx_push_req, tx_push, tx_pop;

  assign tx_full  = (tx_wp[TX_DEPTH_LOG2] != tx_rp[TX_DEPTH_LOG2]) &&
                    (tx_wp[TX_DEPTH_LOG2-1:0] == tx_rp[TX_DEPTH_LOG2-1:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_push_req = wr & hit_tx;
  // A drain-pop in the same cycle frees the slot, so a push on full still lands.
  assign tx_push  = tx_push_req & (~tx_full | tx_pop);

  // TX FIFO pointers.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + TX_PTR_ONE;
    end
  end

  // TX FIFO storage.
  // NOTE: storage arrays are not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TX_DEPTH_LOG2-1:0]] <= mem_wdata[7:0];
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]             rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2:0] rx_wp, rx_rp;
  logic                   rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]             rx_head;

  assign rx_full  = (rx_wp[RX_DEPTH_LOG2] != rx_rp[RX_DEPTH_LOG2]) &&
                    (rx_wp[RX_DEPTH_LOG2-1:0] == rx_rp[RX_DEPTH_LOG2-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_head  = rx_mem[rx_rp[RX_DEPTH_LOG2-1:0]];
  assign rx_pop   = rd & hit_rx & ~rx_empty;
  // A CPU pop in the same cycle makes room for the incoming byte.
  assign rx_push  = rx_dv & (~rx_full | rx_pop);

  // RX FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_PTR_ONE;
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RX_DEPTH_LOG2-1:0]] <= rx_byte;
  end

  // ---------------------------------------------------------------------------
  // Sticky overflow flags and interrupt enable
  // ---------------------------------------------------------------------------
  logic txovf, rxovf, irq_en_bit;

  // Overflow flags: a fresh overflow in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txovf <= 1'b0;
      rxovf <= 1'b0;
    end else begin
      if (wr && hit_st && mem_wdata[3]) txovf <= 1'b0;
      if (wr && hit_st && mem_wdata[4]) rxovf <= 1'b0;
      if (tx_push_req && !tx_push)      txovf <= 1'b1;
      if (rx_dv && !rx_push)            rxovf <= 1'b1;
    end
  end

`ifdef UART_IRQ_EN
  logic irq_en;
  assign irq_en_bit = irq_en;

  // Interrupt enable is a plain read/write bit of STATUS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              irq_en <= 1'b0;
    else if (wr && hit_st)  irq_en <= mem_wdata[2];
  end

  // Registered interrupt: RX data waiting or RX overrun, when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_en & (~rx_empty | rxovf);
  end
`else
  assign irq_en_bit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read data register
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;
  assign status_word = {27'b0, rxovf, txovf, irq_en_bit, ~rx_empty, ~tx_full};

  // Read data is captured on the read strobe and held until the next IO read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
    end else if (rd) begin
      if (hit_tx)      mem_rdata <= '0;
      else if (hit_rx) mem_rdata <= {24'b0, rx_empty ? 8'h00 : rx_head};
      else if (hit_st) mem_rdata <= status_word;
      else             mem_rdata <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX drain FSM
  // ---------------------------------------------------------------------------
  tx_state_e  state, state_nxt;
  logic [1:0] busy_cnt, busy_cnt_nxt;

  // State, timeout counter and the byte handed to uart_tx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy_cnt <= 2'd0;
      tx_byte  <= 8'h00;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      if (tx_pop) tx_byte <= tx_mem[tx_rp[TX_DEPTH_LOG2-1:0]];
    end
  end

  // Next-state and output decode; BUSY gives uart_tx four cycles to raise tx_active.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    tx_pop       = 1'b0;
    tx_dv        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tx_empty && !tx_active) begin
          tx_pop    = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        tx_dv        = 1'b1;
        busy_cnt_nxt = 2'd0;
        state_nxt    = S_BUSY;
      end
      S_BUSY: begin
        if (tx_active)              state_nxt    = S_DONE;
        else if (busy_cnt == 2'd3)  state_nxt    = S_IDLE;
        else                        busy_cnt_nxt = busy_cnt + 2'd1;
      end
      S_DONE: begin
        if (!tx_active) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address and data bits outside the register map are intentionally ignored.
  logic unused_bits;
`ifdef UART_IRQ_EN
  assign unused_bits = ^{mem_addr[31:23], mem_addr[21:6], mem_addr[2:0], mem_wdata[31:8],
                         mem_wdata[1:0], mem_wdata[7:5]};
`else
  assign unused_bits = ^{mem_addr[31:23], mem_addr[21:6], mem_addr[2:0], mem_wdata[31:8],
                         mem_wdata[2:0], mem_wdata[7:5]};
`endif

endmodule
